ccu_snoop_resp_collector: RTL
=============================

Name: ccu_snoop_resp_collector

Overview:
- Sits between the CCU snoop-request path and the per-group snoop ports.
- Accepts one coherent snoop request and fans it out on AC to a selectable subset of NoSnoopPorts caches.
- Collects every CR response, OR-reduces them, and hands a single aggregated result to the downstream CCU FSM that decides between a memory access and a cache-to-cache transfer.
- One transaction in flight at a time.

Parameters:
- NoSnoopPorts, 4, number of snooped caches (≥1).
- AcAddrWidth, 64, AC address width.
- AcSnoopWidth, 4, AC snoop opcode width.
- CrRespWidth, 5, CR response width, fixed by ccu_pkg.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- req_valid_i  in  1  snoop request valid.
- req_ready_o  out  1  snoop request ready.
- req_addr_i  in  AcAddrWidth  line address.
- req_snoop_i  in  AcSnoopWidth  snoop opcode.
- req_mask_i  in  NoSnoopPorts  ports to snoop; initiator bit is already cleared.
- snp_ac_valid_o  out  NoSnoopPorts  per-port AC valid.
- snp_ac_ready_i  in  NoSnoopPorts  per-port AC ready.
- snp_ac_addr_o  out  AcAddrWidth  broadcast address.
- snp_ac_snoop_o  out  AcSnoopWidth  broadcast opcode.
- snp_cr_valid_i  in  NoSnoopPorts  per-port CR valid.
- snp_cr_ready_o  out  NoSnoopPorts  per-port CR ready.
- snp_cr_resp_i  in  NoSnoopPorts*CrRespWidth  per-port CR response; port k occupies bits [k*5 +: 5].
- res_valid_o  out  1  aggregated result valid.
- res_ready_i  in  1  aggregated result ready.
- res_resp_o  out  CrRespWidth  OR of all collected CR responses.
- res_data_mask_o  out  NoSnoopPorts  ports that reported DataTransfer.
- stat_snoops_o  out  32  snoop transaction count.
- stat_data_hits_o  out  32  count of transactions with DataTransfer.
- stat_max_lat_o  out  16  maximum latency observed.

Behaviour:
- CR response bits: [0] DataTransfer, [1] Error, [2] PassDirty, [3] IsShared, [4] WasUnique.
- FSM states: IDLE, SNOOP, RESP. Reset state is IDLE.
- Reset values: all valids and readies 0, res_resp_o 0, res_data_mask_o 0, stat outputs 0.
- IDLE:
  - req_ready_o=1.
  - On handshake: latch addr, snoop and mask; clear ac_sent, cr_got, acc_resp and data_mask.
  - mask==0 → RESP with a zero result, res_valid_o high the next cycle.
  - Otherwise → SNOOP.
- SNOOP:
  - snp_ac_valid_o[k] = mask[k] & ~ac_sent[k]. The first AC valid appears the cycle after request acceptance.
  - ac_sent[k] is set on each port's own handshake; ports complete independently, and valid never drops before ready.
  - snp_cr_ready_o[k] = mask[k] & ac_sent[k] & ~cr_got[k]. A CR arriving in the same cycle as its AC handshake is not accepted until the next cycle.
  - On CR handshake: acc_resp |= resp_k; data_mask[k] = resp_k[0]; cr_got[k] = 1.
  - When (cr_got | handshakes this cycle) == mask → RESP next cycle. Simultaneous CRs from all ports are accepted in one cycle.
- RESP:
  - res_valid_o=1, with res_resp_o=acc_resp and res_data_mask_o=data_mask held stable.
  - On res_ready_i → IDLE. req_ready_o stays low until IDLE, so back-to-back transactions have at least a 1-cycle gap.
- CR valid from an unmasked or already-responded port is never readied; it stays pending, with no side effect.
- rst_i mid-transaction: abort immediately, return to IDLE, drop all valids. Caches must be reset together with the collector.
- Minimum latency from request acceptance to res_valid_o is 3 cycles (AC, CR, RESP); it is 1 cycle for an empty mask.

Optional Feature:
- Macro: CCU_SNOOP_RESP_STATS_EN.
- Defined:
  - stat_snoops_o increments on each RESP handshake.
  - stat_data_hits_o increments on a RESP handshake when res_resp_o[0]=1.
  - stat_max_lat_o holds the maximum cycle count from request handshake to res_valid_o rise; the latency counter saturates at 16'hFFFF.
  - All counters wrap at 2^32 except the saturating latency counter.
- Undefined: stat ports are present, tied to 0, and no counter flops are inferred.

Decomposition:
- ccu_pkg additions:
  - cr_resp_t, a packed struct {was_unique, is_shared, pass_dirty, error, data_transfer}.
  - CR_RESP_WIDTH=5 and AC_SNOOP_WIDTH=4.
  - collector_state_e {IDLE, SNOOP, RESP}.
- Sub-module ccu_snoop_port_ctrl, one instance per port: holds the ac_sent/cr_got flags and produces that port's ac_valid/cr_ready. The top level instantiates it with a generate loop.

Test Plan:
- mask=4'b0110, all AC ready, CRs 5'b00001 (port1) and 5'b01000 (port2) → res_resp_o=5'b01001, res_data_mask_o=4'b0010, res_valid_o at cycle 3 after acceptance.
- mask=0 → res_valid_o one cycle after acceptance, res_resp_o=0, snp_ac_valid_o never asserted.
- Port3 snp_ac_ready_i held low 10 cycles, others immediate → snp_ac_valid_o[3] stays high throughout; no port3 CR readied before its AC handshake; result only after port3 responds.
- All 4 CRs valid in the same cycle with mask=4'hF → all readied in one cycle; result = OR of all four; result held while res_ready_i=0 for 5 cycles.
- Unmasked port0 asserts snp_cr_valid_i during a transaction → snp_cr_ready_o[0] stays 0 and the result is unaffected.
- rst_i pulsed in SNOOP → next cycle all valids 0, req_ready_o=1; with CCU_SNOOP_RESP_STATS_EN defined, 3 transactions (1 with DataTransfer) → stat_snoops_o=3, stat_data_hits_o=1.

Source files
------------

// File: rtl/ccu_pkg.sv
// Shared CCU types for the snoop response collector.
package ccu_pkg;

    localparam int CR_RESP_WIDTH  = 5;
    localparam int AC_SNOOP_WIDTH = 4;

    typedef struct packed {
        logic was_unique;
        logic is_shared;
        logic pass_dirty;
        logic error;
        logic data_transfer;
    } cr_resp_t;

    typedef enum logic [1:0] {
        IDLE,
        SNOOP,
        RESP
    } collector_state_e;

endpackage

// File: rtl/ccu_snoop_port_ctrl.sv
// Per-port AC/CR sequencing: one AC handshake, then one CR handshake.
module ccu_snoop_port_ctrl (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic active,
    input  logic mask,
    input  logic ac_ready,
    input  logic cr_valid,
    output logic ac_valid,
    output logic cr_ready,
    output logic done
);

    logic ac_sent;
    logic cr_got;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            ac_sent <= 1'b0;
            cr_got  <= 1'b0;
        end else begin
            if (ac_valid && ac_ready) ac_sent <= 1'b1;
            if (cr_ready && cr_valid) cr_got  <= 1'b1;
        end
    end

    // CR is only readied once the AC handshake is already registered
    assign ac_valid = active & mask & ~ac_sent;
    assign cr_ready = active & mask & ac_sent & ~cr_got;
    assign done     = cr_got | (cr_ready & cr_valid);

endmodule

// File: rtl/ccu_snoop_resp_collector.sv
// Fans one snoop out on AC and OR-reduces the CR responses into one result.
// Optional counters enabled by CCU_SNOOP_RESP_STATS_EN.
module ccu_snoop_resp_collector
    import ccu_pkg::*;
#(
    parameter int NoSnoopPorts = 4,
    parameter int AcAddrWidth  = 64,
    parameter int AcSnoopWidth = AC_SNOOP_WIDTH,
    parameter int CrRespWidth  = CR_RESP_WIDTH
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic                                req_valid_i,
    output logic                                req_ready_o,
    input  logic [AcAddrWidth-1:0]              req_addr_i,
    input  logic [AcSnoopWidth-1:0]             req_snoop_i,
    input  logic [NoSnoopPorts-1:0]             req_mask_i,
    output logic [NoSnoopPorts-1:0]             snp_ac_valid_o,
    input  logic [NoSnoopPorts-1:0]             snp_ac_ready_i,
    output logic [AcAddrWidth-1:0]              snp_ac_addr_o,
    output logic [AcSnoopWidth-1:0]             snp_ac_snoop_o,
    input  logic [NoSnoopPorts-1:0]             snp_cr_valid_i,
    output logic [NoSnoopPorts-1:0]             snp_cr_ready_o,
    input  logic [NoSnoopPorts*CrRespWidth-1:0] snp_cr_resp_i,
    output logic                                res_valid_o,
    input  logic                                res_ready_i,
    output logic [CrRespWidth-1:0]              res_resp_o,
    output logic [NoSnoopPorts-1:0]             res_data_mask_o,
    output logic [31:0]                         stat_snoops_o,
    output logic [31:0]                         stat_data_hits_o,
    output logic [15:0]                         stat_max_lat_o
);

    collector_state_e state_q, state_d;
    logic [AcAddrWidth-1:0]  addr_q;
    logic [AcSnoopWidth-1:0] snoop_q;
    logic [NoSnoopPorts-1:0] mask_q, dmask_q, dmask_d, done, cr_hs;
    cr_resp_t                acc_q, acc_d;
    logic                    accept, active, res_hs;

    assign req_ready_o = (state_q == IDLE) & ~rst_i;
    assign res_valid_o = (state_q == RESP) & ~rst_i;
    assign active      = (state_q == SNOOP) & ~rst_i;
    assign accept      = req_valid_i & req_ready_o;
    assign res_hs      = res_valid_o & res_ready_i;
    assign cr_hs       = snp_cr_valid_i & snp_cr_ready_o;

    for (genvar k = 0; k < NoSnoopPorts; k++) begin : g_port
        ccu_snoop_port_ctrl u_port (
            .clk      (clk_i),
            .rst      (rst_i),
            .clear    (accept),
            .active   (active),
            .mask     (mask_q[k]),
            .ac_ready (snp_ac_ready_i[k]),
            .cr_valid (snp_cr_valid_i[k]),
            .ac_valid (snp_ac_valid_o[k]),
            .cr_ready (snp_cr_ready_o[k]),
            .done     (done[k])
        );
    end

    always_comb begin
        cr_resp_t r;
        r       = '0;
        acc_d   = acc_q;
        dmask_d = dmask_q;
        for (int k = 0; k < NoSnoopPorts; k++) begin
            r = snp_cr_resp_i[k*CR_RESP_WIDTH +: CR_RESP_WIDTH];
            if (cr_hs[k]) begin
                acc_d      = acc_d | r;
                dmask_d[k] = r.data_transfer;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:  if (accept) state_d = (req_mask_i == '0) ? RESP : SNOOP;
            SNOOP: if (done == mask_q) state_d = RESP;
            RESP:  if (res_ready_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            addr_q  <= '0;
            snoop_q <= '0;
            mask_q  <= '0;
            acc_q   <= '0;
            dmask_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                addr_q  <= req_addr_i;
                snoop_q <= req_snoop_i;
                mask_q  <= req_mask_i;
                acc_q   <= '0;
                dmask_q <= '0;
            end else if (state_q == SNOOP) begin
                acc_q   <= acc_d;
                dmask_q <= dmask_d;
            end
        end
    end

    assign snp_ac_addr_o   = addr_q;
    assign snp_ac_snoop_o  = snoop_q;
    assign res_resp_o      = acc_q;
    assign res_data_mask_o = dmask_q;

`ifdef CCU_SNOOP_RESP_STATS_EN
    logic [31:0] snoops_q, hits_q;
    logic [15:0] lat_q, max_q;

    // lat_q is frozen in RESP, so it equals the accept-to-valid latency there
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            snoops_q <= '0;
            hits_q   <= '0;
            lat_q    <= '0;
            max_q    <= '0;
        end else begin
            if (accept) lat_q <= 16'd1;
            else if (state_q == SNOOP && lat_q != 16'hFFFF) lat_q <= lat_q + 16'd1;
            if (state_q == RESP && lat_q > max_q) max_q <= lat_q;
            if (res_hs) begin
                snoops_q <= snoops_q + 32'd1;
                if (acc_q.data_transfer) hits_q <= hits_q + 32'd1;
            end
        end
    end

    assign stat_snoops_o    = snoops_q;
    assign stat_data_hits_o = hits_q;
    assign stat_max_lat_o   = max_q;
`else
    assign stat_snoops_o    = '0;
    assign stat_data_hits_o = '0;
    assign stat_max_lat_o   = '0;
`endif

endmodule
